// File: rtl/hwf_log_lut.sv
// hwf_log_lut
// Registered constant table of -log2(1 - 2^-i) in unsigned 8.8 fixed point,
// indexed by the hwf kernel's iteration counter. The kernel's Ei stage
// subtracts this value every iteration, so the output is registered to keep
// the index-to-value path off the kernel's subtract timing.
//
// Values are round-to-nearest of 256 * (-log2(1 - 2^-i)). Index 0 has an
// infinite true value and saturates to all ones. From index 10 onward the
// term falls below half an LSB and rounds to zero, as does every index
// outside the table.
module hwf_log_lut #(
    parameter int IDX_W = 32,
    // Output format is unsigned 8.8; only 16 is supported.
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i,
    output logic [OUT_W-1:0] log_val
);

    // Number of populated table entries. The full index width is compared
    // against this, so large indices never alias onto low entries.
    localparam logic [IDX_W-1:0] TABLE_DEPTH = IDX_W'(16);

    logic             in_range;
    logic [3:0]       idx;
    logic [OUT_W-1:0] lut_val;

    assign in_range = (i < TABLE_DEPTH);
    assign idx      = i[3:0];

    // Table lookup; anything outside the populated range reads as zero.
    always_comb begin
        lut_val = '0;
        if (in_range) begin
            case (idx)
                4'd0:    lut_val = 16'hFFFF;
                4'd1:    lut_val = 16'h0100;
                4'd2:    lut_val = 16'h006A;
                4'd3:    lut_val = 16'h0031;
                4'd4:    lut_val = 16'h0018;
                4'd5:    lut_val = 16'h000C;
                4'd6:    lut_val = 16'h0006;
                4'd7:    lut_val = 16'h0003;
                4'd8:    lut_val = 16'h0001;
                4'd9:    lut_val = 16'h0001;
                default: lut_val = 16'h0000;
            endcase
        end
    end

    // Output register: cleared asynchronously, otherwise reloaded every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_val <= '0;
        end else begin
            log_val <= lut_val;
        end
    end

endmodule

// File: tb/tb_hwf_log_lut.sv
module tb_hwf_log_lut;

    logic        clk;
    logic        rst;
    logic [31:0] i;
    logic [15:0] log_val;

    int n_cmp;
    int n_err;

    logic [15:0] tbl [16];

    hwf_log_lut #(.IDX_W(32), .OUT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .log_val (log_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        i   = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected %h", log_val, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0100) begin
            n_err++;
            $display("FAIL reset_release: got %h expected %h", log_val, 16'h0100);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] prev;
        prev = 16'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            i = 32'(k);
            @(posedge clk);
            #1;
            n_cmp++;
            if (log_val !== tbl[k]) begin
                n_err++;
                $display("FAIL sweep_i%0d: got %h expected %h", k, log_val, tbl[k]);
            end
            if (k >= 2) begin
                n_cmp++;
                if (log_val > prev) begin
                    n_err++;
                    $display("FAIL monotonic_i%0d: got %h expected <= %h", k, log_val, prev);
                end
            end
            prev = log_val;
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] vec [4];
        vec[0] = 32'd16;
        vec[1] = 32'd17;
        vec[2] = 32'd255;
        vec[3] = 32'h8000_0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i = vec[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if (log_val !== 16'h0000) begin
                n_err++;
                $display("FAIL oor_%h: got %h expected %h", vec[k], log_val, 16'h0000);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        i = 32'd2;
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h006A) begin
            n_err++;
            $display("FAIL lat_load: got %h expected %h", log_val, 16'h006A);
        end
        #1;
        i = 32'd3;
        #1;
        n_cmp++;
        if (log_val !== 16'h006A) begin
            n_err++;
            $display("FAIL lat_comb_path: got %h expected %h", log_val, 16'h006A);
        end
        @(negedge clk);
        n_cmp++;
        if (log_val !== 16'h006A) begin
            n_err++;
            $display("FAIL lat_hold: got %h expected %h", log_val, 16'h006A);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0031) begin
            n_err++;
            $display("FAIL lat_update: got %h expected %h", log_val, 16'h0031);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        i = 32'd1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0100) begin
            n_err++;
            $display("FAIL async_pre: got %h expected %h", log_val, 16'h0100);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (log_val !== 16'h0000) begin
            n_err++;
            $display("FAIL async_drop: got %h expected %h", log_val, 16'h0000);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (log_val !== 16'h0000) begin
            n_err++;
            $display("FAIL async_no_stale: got %h expected %h", log_val, 16'h0000);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0100) begin
            n_err++;
            $display("FAIL async_resume: got %h expected %h", log_val, 16'h0100);
        end
        // Reset raised right at an active edge must win.
        @(posedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (log_val !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_at_edge: got %h expected %h", log_val, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (log_val !== 16'h0100) begin
            n_err++;
            $display("FAIL rst_at_edge_resume: got %h expected %h", log_val, 16'h0100);
        end
    endtask

    task automatic test_kernel();
        logic [15:0] ei;
        logic [15:0] held;
        ei = 16'h0500;
        @(negedge clk);
        i = 32'd0;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            held = log_val;
            n_cmp++;
            if (log_val !== tbl[k]) begin
                n_err++;
                $display("FAIL kernel_i%0d: got %h expected %h", k, log_val, tbl[k]);
            end
            ei = ei - log_val;
            @(negedge clk);
            n_cmp++;
            if (log_val !== held) begin
                n_err++;
                $display("FAIL kernel_midcycle_i%0d: got %h expected %h", k, log_val, held);
            end
            i = 32'(k + 1);
        end
        // 0x500 - (0xFFFF + 457) mod 2^16 = 0x338
        n_cmp++;
        if (ei !== 16'h0338) begin
            n_err++;
            $display("FAIL kernel_ei: got %h expected %h", ei, 16'h0338);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tbl[0]  = 16'hFFFF; tbl[1]  = 16'h0100; tbl[2]  = 16'h006A; tbl[3]  = 16'h0031;
        tbl[4]  = 16'h0018; tbl[5]  = 16'h000C; tbl[6]  = 16'h0006; tbl[7]  = 16'h0003;
        tbl[8]  = 16'h0001; tbl[9]  = 16'h0001; tbl[10] = 16'h0000; tbl[11] = 16'h0000;
        tbl[12] = 16'h0000; tbl[13] = 16'h0000; tbl[14] = 16'h0000; tbl[15] = 16'h0000;
        rst = 1'b1;
        i   = 32'd1;

        test_reset();
        test_sweep();
        test_out_of_range();
        test_latency();
        test_async_reset();
        test_kernel();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hwf_log_lut.md
Name: hwf_log_lut

Overview:
- Registered constant lookup table for the hardware-friendly (base-2) kernel datapath.
- For iteration index i it returns -log2(1 - 2^-i) in unsigned 8.8 fixed point.
- The hwf kernel's Ei stage subtracts this value from Ei each iteration; the result drives the di decision and the Bi shift-subtract update.
- Pure ROM plus one output register. No internal state besides that register.

Parameters:
- IDX_W, 32, width of the index input. It matches the integer iteration counter in the kernel.
- OUT_W, 16, output width, unsigned 8.8 (8 integer bits, 8 fraction bits). Fixed at 16; other values are unsupported.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- i, input, IDX_W, iteration index. Treated as unsigned.
- log_val, output, OUT_W, registered table value for the index sampled at the previous rising edge.

Behaviour:
- Reset:
  - rst high clears log_val to 16'h0000 immediately (asynchronous), without waiting for a clock edge.
  - log_val holds 0 while rst is high.
  - The first clock edge after rst deasserts loads the table value for the current i.
- Latency:
  - On each rising clk with rst low, log_val <= TABLE(i).
  - Exactly one cycle from a change on i to a change on log_val.
  - No enable. The register updates every cycle.
- Table, round-to-nearest of 256*(-log2(1-2^-i)):
  - i=0 -> 16'hFFFF (true value is infinite; saturate)
  - i=1 -> 256 (16'h0100)
  - i=2 -> 106 (16'h006A)
  - i=3 -> 49 (16'h0031)
  - i=4 -> 24 (16'h0018)
  - i=5 -> 12 (16'h000C)
  - i=6 -> 6 (16'h0006)
  - i=7 -> 3 (16'h0003)
  - i=8 -> 1 (16'h0001)
  - i=9 -> 1 (16'h0001)
  - i=10..15 -> 0
- Out-of-range:
  - Any i >= 16, including all values with nonzero upper IDX_W-4 bits, yields 0.
  - The full IDX_W-bit value is compared. No truncation aliasing, so i=17 must not return TABLE(1).
- Constants are hard-coded in a case statement. No real-number or $ln use in synthesizable code.
- Output is monotonically non-increasing for i >= 1. The bench checks this property.
- Simultaneous rst assertion and clock edge: reset wins, log_val = 0.
- Reset mid-stream: log_val goes to 0 at once. Normal lookup resumes on the first edge after release. No stale value is output.
- No X propagation: an unknown i is not required to be handled. A known i always produces a defined value from the table or the default 0.

Test Plan:
- Reset check: assert rst with i=1, wait 3 clocks -> log_val = 0. Deassert rst, one clock -> log_val = 16'h0100.
- Full table sweep: drive i = 0..15, one per clock. One cycle later, check the sequence FFFF, 0100, 006A, 0031, 0018, 000C, 0006, 0003, 0001, 0001, then 0 for i=10..15.
- Out-of-range aliasing: i=16, 17, 255, 32'h8000_0001 -> log_val = 0 one cycle later each, never 0100 or 006A.
- Latency check: hold i=2, then change to i=3 mid-cycle.
  - log_val stays 006A until the next rising edge, then becomes 0031.
  - No combinational path from i to log_val.
- Asynchronous reset mid-operation: with i=1 and log_val=0100, pulse rst between clock edges.
  - log_val drops to 0 before the next edge.
  - After release, the next edge restores 0100.
- Kernel-style usage: counter i incrementing 0..8, subtract log_val from Ei=16'h0500 each cycle.
  - Sampled log_val sequence matches the table with a one-cycle lag.
  - No value is written outside clock edges.
